// File: rtl/gp_pkg.sv
// rtl/gp_pkg.sv - opcodes, command-word field positions and sequencer state encoding
package gp_pkg;

  localparam logic [7:0] GP_OP_STOP = 8'h00;
  localparam logic [7:0] GP_OP_FILL = 8'h01;
  localparam logic [7:0] GP_OP_LINE = 8'h02;

  localparam int OP_LSB  = 24;
  localparam int COLOR_W = 24;
  localparam int X_LSB   = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_REQ,
    S_HDR_WAIT,
    S_ARG_REQ,
    S_ARG_WAIT,
    S_DISPATCH
  } gp_state_t;

endpackage

// File: rtl/gp_word_fetch.sv
// rtl/gp_word_fetch.sv - single-outstanding req/gnt/rvalid word reader with auto-incrementing pointer
module gp_word_fetch #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              req_en,
  input  logic              wait_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              word_valid,
  output logic [31:0]       word_data
);

  logic [ADDR_W-1:0] ptr;

  // Pointer advances on grant, not on data, so it already names the next word while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_addr & ~ADDR_W'(3);
    end else if (req_en && mem_gnt) begin
      ptr <= ptr + ADDR_W'(4);
    end
  end

  assign mem_req    = req_en;
  assign mem_addr   = ptr;
  assign word_valid = wait_en & mem_rvalid;
  assign word_data  = mem_rdata;

endmodule

// File: rtl/gp_cmd_sequencer.sv
// rtl/gp_cmd_sequencer.sv - command fetch/decode/dispatch sequencer; GP_ILLEGAL_TRAP_EN traps unknown opcodes
module gp_cmd_sequencer
  import gp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int COORD_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gp_start,
  input  logic [ADDR_W-1:0]  gp_code_addr,
  input  logic [ADDR_W-1:0]  gp_frame_addr,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [31:0]        mem_rdata,
  output logic               fill_valid,
  input  logic               fill_ready,
  output logic               line_valid,
  input  logic               line_ready,
  output logic [23:0]        cmd_color,
  output logic [ADDR_W-1:0]  cmd_frame,
  output logic [COORD_W-1:0] line_x0,
  output logic [COORD_W-1:0] line_y0,
  output logic [COORD_W-1:0] line_x1,
  output logic [COORD_W-1:0] line_y1,
  output logic               gp_busy,
  output logic               gp_done,
  output logic               gp_err
);

  gp_state_t   state, state_d;
  logic        req_en, wait_en, word_valid;
  logic [31:0] word_data;
  logic [7:0]  op;
  logic        start_ok, hdr_ok, arg_ok;
  logic        cmd_is_line, arg_idx;

  assign op       = word_data[OP_LSB +: 8];
  assign start_ok = (state == S_IDLE) && gp_start;
  assign hdr_ok   = (state == S_HDR_WAIT) && word_valid;
  assign arg_ok   = (state == S_ARG_WAIT) && word_valid;

  gp_word_fetch #(.ADDR_W(ADDR_W)) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .load       (start_ok),
    .load_addr  (gp_code_addr),
    .req_en     (req_en),
    .wait_en    (wait_en),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (gp_start) state_d = S_HDR_REQ;
      S_HDR_REQ:  if (mem_gnt) state_d = S_HDR_WAIT;
      S_HDR_WAIT: begin
        if (word_valid) begin
          case (op)
            GP_OP_STOP: state_d = S_IDLE;
            GP_OP_FILL: state_d = S_DISPATCH;
            GP_OP_LINE: state_d = S_ARG_REQ;
`ifdef GP_ILLEGAL_TRAP_EN
            default:    state_d = S_IDLE;
`else
            default:    state_d = S_HDR_REQ;
`endif
          endcase
        end
      end
      S_ARG_REQ:  if (mem_gnt) state_d = S_ARG_WAIT;
      S_ARG_WAIT: if (word_valid) state_d = arg_idx ? S_DISPATCH : S_ARG_REQ;
      S_DISPATCH: if ((fill_valid && fill_ready) || (line_valid && line_ready)) state_d = S_HDR_REQ;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_en     = 1'b0;
    wait_en    = 1'b0;
    fill_valid = 1'b0;
    line_valid = 1'b0;
    gp_busy    = (state != S_IDLE);
    case (state)
      S_HDR_REQ, S_ARG_REQ:   req_en = 1'b1;
      S_HDR_WAIT, S_ARG_WAIT: wait_en = 1'b1;
      S_DISPATCH: begin
        fill_valid = !cmd_is_line;
        line_valid = cmd_is_line;
      end
      default: ;
    endcase
  end

  // Payload registers only load on fetched words, so they stay frozen throughout DISPATCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gp_done     <= 1'b0;
      cmd_frame   <= '0;
      cmd_color   <= '0;
      cmd_is_line <= 1'b0;
      arg_idx     <= 1'b0;
      line_x0     <= '0;
      line_y0     <= '0;
      line_x1     <= '0;
      line_y1     <= '0;
    end else begin
      gp_done <= hdr_ok && (op == GP_OP_STOP);
      if (start_ok) cmd_frame <= gp_frame_addr;
      if (hdr_ok && (op == GP_OP_FILL || op == GP_OP_LINE)) begin
        cmd_color   <= word_data[COLOR_W-1:0];
        cmd_is_line <= (op == GP_OP_LINE);
        arg_idx     <= 1'b0;
      end
      if (arg_ok) begin
        arg_idx <= 1'b1;
        if (!arg_idx) begin
          line_x0 <= word_data[X_LSB +: COORD_W];
          line_y0 <= word_data[0 +: COORD_W];
        end else begin
          line_x1 <= word_data[X_LSB +: COORD_W];
          line_y1 <= word_data[0 +: COORD_W];
        end
      end
    end
  end

`ifdef GP_ILLEGAL_TRAP_EN
  logic op_unknown;
  logic err_q;
  assign op_unknown = !(op inside {GP_OP_STOP, GP_OP_FILL, GP_OP_LINE});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     err_q <= 1'b0;
    else if (start_ok)            err_q <= 1'b0;
    else if (hdr_ok && op_unknown) err_q <= 1'b1;
  end
  assign gp_err = err_q;
`else
  assign gp_err = 1'b0;
`endif

endmodule

// File: tb/tb_gp_cmd_sequencer.sv
// tb/tb_gp_cmd_sequencer.sv - self-checking bench: table-loaded command lists, scoreboarded dispatches
module tb_gp_cmd_sequencer;

`ifdef GP_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rst, gp_start;
  logic [31:0] gp_code_addr, gp_frame_addr;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata;
  logic        fill_valid, fill_ready, line_valid, line_ready;
  logic [23:0] cmd_color;
  logic [31:0] cmd_frame;
  logic [15:0] line_x0, line_y0, line_x1, line_y1;
  logic        gp_busy, gp_done, gp_err;

  gp_cmd_sequencer dut (
    .clk(clk), .rst(rst), .gp_start(gp_start), .gp_code_addr(gp_code_addr),
    .gp_frame_addr(gp_frame_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .line_valid(line_valid),
    .line_ready(line_ready), .cmd_color(cmd_color), .cmd_frame(cmd_frame),
    .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
    .gp_busy(gp_busy), .gp_done(gp_done), .gp_err(gp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] w0, w1, w2;
    int          nw;
    bit          exp_valid;
    bit          exp_line;
    logic [23:0] color;
    logic [15:0] x0, y0, x1, y1;
  } vec_t;

  typedef struct {
    bit          line;
    logic [23:0] color;
    logic [15:0] x0, y0, x1, y1;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb[$];
  logic [31:0] mem[logic [31:0]];

  int checks = 0, failures = 0;
  int done_cnt = 0;
  logic [31:0] exp_frame = '0;

  int gnt_delay = 0, rv_delay = 1, gnt_count = 0;
  int stall_left = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic load_vecs(input logic [31:0] base, input int lo, input int hi, input bit push);
    logic [31:0] a;
    exp_t e;
    a = base & ~32'h3;
    for (int i = lo; i <= hi; i++) begin
      mem[a] = vecs[i].w0; a = a + 32'd4;
      if (vecs[i].nw > 1) begin mem[a] = vecs[i].w1; a = a + 32'd4; end
      if (vecs[i].nw > 2) begin mem[a] = vecs[i].w2; a = a + 32'd4; end
      if (push && vecs[i].exp_valid) begin
        e.line = vecs[i].exp_line; e.color = vecs[i].color;
        e.x0 = vecs[i].x0; e.y0 = vecs[i].y0; e.x1 = vecs[i].x1; e.y1 = vecs[i].y1;
        sb.push_back(e);
      end
    end
  endtask

  // Memory responder: programmable grant delay and read latency, one read outstanding.
  initial begin
    int rcnt, wcnt;
    bit waiting;
    logic [31:0] raddr, held;
    rcnt = -1; wcnt = 0; waiting = 0; raddr = '0; held = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (rcnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rd(raddr); rcnt = -1; end
      else if (rcnt > 0) rcnt--;
      if (!rst) begin
        waiting = 0; wcnt = 0;
      end else if (mem_req && rcnt < 0) begin
        if (waiting) chk("req_hold_addr", mem_addr, held);
        if (wcnt < gnt_delay) begin
          if (!waiting) held = mem_addr;
          waiting = 1; wcnt++;
        end else begin
          mem_gnt = 1'b1; raddr = mem_addr; rcnt = rv_delay - 1;
          wcnt = 0; waiting = 0; gnt_count++;
        end
      end else if (!mem_req) begin
        if (waiting) chk("req_hold_req", mem_req, 1'b1);
        waiting = 0; wcnt = 0;
      end
    end
  end

  // Engine side: fill stall on request, line ready randomised, ready often high with no valid.
  initial begin
    bit active;
    logic [23:0] scolor;
    active = 0; scolor = '0;
    fill_ready = 1'b0; line_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (fill_valid && stall_left > 0) begin
        if (active) begin
          chk("stall_color", cmd_color, scolor);
          chk("stall_no_req", mem_req, 1'b0);
        end else begin
          active = 1; scolor = cmd_color;
        end
        stall_left--;
        fill_ready = 1'b0;
      end else begin
        active = 0;
        fill_ready = 1'b1;
      end
      line_ready = 1'($urandom_range(0, 1));
    end
  end

  // Dispatch monitor on the falling edge: exclusivity, payload hold, scoreboard pop, done count.
  initial begin
    bit pend;
    logic [89:0] snap;
    exp_t e;
    pend = 0; snap = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin pend = 0; continue; end
      if (gp_done) done_cnt++;
      if (fill_valid || line_valid) chk("valid_exclusive", fill_valid & line_valid, 1'b0);
      if (pend) chk("payload_hold", {line_valid, fill_valid, cmd_color, line_x0, line_y0, line_x1, line_y1}, snap);
      if ((fill_valid && fill_ready) || (line_valid && line_ready)) begin
        pend = 0;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_dispatch actual=line%0b color=%0h required=none", line_valid, cmd_color);
        end else begin
          e = sb.pop_front();
          chk("disp_kind", line_valid, e.line);
          chk("disp_color", cmd_color, e.color);
          chk("disp_frame", cmd_frame, exp_frame);
          if (e.line) chk("disp_coords", {line_x0, line_y0, line_x1, line_y1}, {e.x0, e.y0, e.x1, e.y1});
        end
      end else if (fill_valid || line_valid) begin
        pend = 1;
        snap = {line_valid, fill_valid, cmd_color, line_x0, line_y0, line_x1, line_y1};
      end
    end
  end

  task automatic run_list(input logic [31:0] base, input logic [31:0] frame, input int exp_lat,
                          input int glitch_at, input int exp_done, input logic exp_err);
    int cyc;
    bit seen;
    done_cnt = 0; exp_frame = frame;
    @(posedge clk); #1;
    gp_code_addr = base; gp_frame_addr = frame; gp_start = 1'b1;
    @(posedge clk); #1;
    gp_start = 1'b0; gp_code_addr = 32'h0000_3000; gp_frame_addr = 32'h5555_0000;
    cyc = 0; seen = 0;
    while (gp_busy && cyc < 3000) begin
      if (!seen && (fill_valid || line_valid)) begin
        seen = 1;
        if (exp_lat > 0) chk("start_to_valid_latency", cyc + 1, exp_lat);
      end
      gp_start = (glitch_at > 0 && cyc == glitch_at);
      @(posedge clk); #1;
      cyc++;
    end
    gp_start = 1'b0;
    chk("list_finished_in_budget", cyc < 3000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_count", done_cnt, exp_done);
    chk("sb_drained", sb.size(), 0);
    chk("err_flag", gp_err, exp_err);
    chk("frame_latched", cmd_frame, frame);
    chk("idle_after_list", gp_busy, 1'b0);
  endtask

  initial begin
    int g0, bad, tmo;
    rst = 1'b0; gp_start = 1'b0; gp_code_addr = '0; gp_frame_addr = '0;

    // idx 0-3: reference list
    vecs.push_back('{32'h01000000, 32'h0, 32'h0, 1, 1, 0, 24'h000000, 16'd0, 16'd0, 16'd0, 16'd0});
    vecs.push_back('{32'h020000ff, 32'h00100020, 32'h001a002b, 3, 1, 1, 24'h0000ff, 16'd16, 16'd32, 16'd26, 16'd43});
    vecs.push_back('{32'h02ff0000, 32'h01230124, 32'h00aa00bb, 3, 1, 1, 24'hff0000, 16'd291, 16'd292, 16'd170, 16'd187});
    vecs.push_back('{32'h00000000, 32'h0, 32'h0, 1, 0, 0, 24'h0, 16'd0, 16'd0, 16'd0, 16'd0});
    // idx 4-7: illegal opcode in the middle
    vecs.push_back('{32'h01000011, 32'h0, 32'h0, 1, 1, 0, 24'h000011, 16'd0, 16'd0, 16'd0, 16'd0});
    vecs.push_back('{32'h7f123456, 32'h0, 32'h0, 1, 0, 0, 24'h0, 16'd0, 16'd0, 16'd0, 16'd0});
    vecs.push_back('{32'h01000022, 32'h0, 32'h0, 1, !TRAP, 0, 24'h000022, 16'd0, 16'd0, 16'd0, 16'd0});
    vecs.push_back('{32'h00000000, 32'h0, 32'h0, 1, 0, 0, 24'h0, 16'd0, 16'd0, 16'd0, 16'd0});
    // idx 8-10: list crossing the top of the address space
    vecs.push_back('{32'h01000055, 32'h0, 32'h0, 1, 1, 0, 24'h000055, 16'd0, 16'd0, 16'd0, 16'd0});
    vecs.push_back('{32'h01000066, 32'h0, 32'h0, 1, 1, 0, 24'h000066, 16'd0, 16'd0, 16'd0, 16'd0});
    vecs.push_back('{32'h00000000, 32'h0, 32'h0, 1, 0, 0, 24'h0, 16'd0, 16'd0, 16'd0, 16'd0});
    // idx 11-12: line aborted by reset
    vecs.push_back('{32'h02abcdef, 32'h00010002, 32'h00030004, 3, 0, 1, 24'habcdef, 16'd1, 16'd2, 16'd3, 16'd4});
    vecs.push_back('{32'h00000000, 32'h0, 32'h0, 1, 0, 0, 24'h0, 16'd0, 16'd0, 16'd0, 16'd0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_valids", {fill_valid, line_valid}, 2'b00);
    chk("rst_status", {gp_busy, gp_done, gp_err}, 3'b000);
    chk("rst_payload", {cmd_color, cmd_frame, line_x0, line_y0, line_x1, line_y1}, '0);
    rst = 1'b1;

    stall_left = 10;
    load_vecs(32'h1780_0000, 0, 3, 1);
    run_list(32'h1780_0000, 32'h2000_0000, 3, 0, 1, 1'b0);

    gnt_delay = 5; rv_delay = 3;
    load_vecs(32'h1780_0000, 0, 3, 1);
    run_list(32'h1780_0000, 32'h2000_0000, 0, 0, 1, 1'b0);
    gnt_delay = 0; rv_delay = 1;

    load_vecs(32'h1780_0000, 0, 3, 1);
    run_list(32'h1780_0000, 32'h2100_0000, 0, 5, 1, 1'b0);

    load_vecs(32'h0000_3000, 4, 7, 1);
    run_list(32'h0000_3000, 32'h3000_0000, 0, 0, TRAP ? 0 : 1, TRAP);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", gp_err, TRAP);

    load_vecs(32'hFFFF_FFF8, 8, 10, 1);
    run_list(32'hFFFF_FFFA, 32'h4000_0000, 0, 0, 1, 1'b0);

    // Reset while the first line argument read is still outstanding.
    rv_delay = 6;
    load_vecs(32'h0000_2000, 11, 12, 0);
    g0 = gnt_count;
    @(posedge clk); #1;
    gp_code_addr = 32'h0000_2000; gp_frame_addr = 32'h6000_0000; gp_start = 1'b1;
    @(posedge clk); #1;
    gp_start = 1'b0;
    tmo = 0;
    while (gnt_count < g0 + 2 && tmo < 100) begin @(posedge clk); #2; tmo++; end
    chk("arg_grant_seen", gnt_count >= g0 + 2, 1'b1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_rst_req_valid", {mem_req, fill_valid, line_valid}, 3'b000);
    chk("async_rst_status", {gp_busy, gp_done, gp_err}, 3'b000);
    chk("async_rst_payload", {cmd_color, cmd_frame, line_x0, line_y0}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #2;
      if (gp_busy || mem_req || fill_valid || line_valid || line_x0 != 16'd0 || line_y0 != 16'd0) bad++;
    end
    chk("late_rvalid_ignored", bad, 0);
    rv_delay = 1;

    load_vecs(32'h1780_0000, 0, 3, 1);
    run_list(32'h1780_0000, 32'h2200_0000, 3, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
